// File: rtl/instruction_fetch_unit.sv
// IF stage and IF/ID register: PC, READ/BUSYWAIT fetch, stall skid buffer, redirect discard.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic [31:0] PC_ID,
   output logic [31:0] PC4_ID,
   output logic [31:0] INSTRUCTION_ID,
   output logic        VALID_ID,
`ifdef IFU_MISALIGN_TRAP_EN
   output logic        MISALIGNED_ID,
`endif
   output logic        IF_BUSY,
   output logic [1:0]  dbg_state
);

   // Handshake: a word transfers on the rising edge where IMEM_READ=1 and
   // IMEM_BUSYWAIT=0; while BUSYWAIT is high the request and address stay put.
`ifdef IFU_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_DISCARD = 2'd2, S_TRAP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_DISCARD = 2'd2} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] disc_addr_q, disc_addr_d;
`ifdef IFU_MISALIGN_TRAP_EN
   logic        mis_q, mis_d;
`endif

   logic        read_req;
   logic        completion;
   logic        waiting;
   logic [31:0] cur_addr;
   logic [31:0] target;

   assign read_req   = (state_q == S_FETCH) || (state_q == S_DISCARD);
   assign completion = read_req & ~IMEM_BUSYWAIT;
   assign waiting    = read_req & IMEM_BUSYWAIT;
   assign cur_addr   = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
   assign target     = BRANCH_TARGET & ~32'h3;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      id_pc_d      = id_pc_q;
      id_pc4_d     = id_pc4_q;
      id_instr_d   = id_instr_q;
      id_valid_d   = id_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      disc_addr_d  = disc_addr_q;
`ifdef IFU_MISALIGN_TRAP_EN
      mis_d        = mis_q;
`endif

      if (BRANCH_TAKEN) begin
         // A redirect flushes IF/ID even under STALL; the skid contents are dead.
         id_pc_d    = 32'h0;
         id_pc4_d   = 32'h0;
         id_instr_d = 32'h0;
         id_valid_d = 1'b0;
         pc_d       = target;
         if (waiting) begin
            state_d     = S_DISCARD;
            disc_addr_d = cur_addr;
         end else begin
            state_d = S_FETCH;
         end
`ifdef IFU_MISALIGN_TRAP_EN
         mis_d = 1'b0;
         // Misaligned target: no fetch, report it in IF/ID and park until re-steered.
         if (BRANCH_TARGET[1:0] != 2'b00) begin
            pc_d     = BRANCH_TARGET;
            id_pc_d  = BRANCH_TARGET;
            id_pc4_d = BRANCH_TARGET + 32'd4;
            mis_d    = 1'b1;
            state_d  = S_TRAP;
         end
`endif
      end else begin
         case (state_q)
            S_FETCH: begin
               if (completion) begin
                  pc_d = pc_q + 32'd4;
                  if (STALL) begin
                     skid_pc_d    = pc_q;
                     skid_instr_d = IMEM_READDATA;
                     state_d      = S_HOLD;
                  end else begin
                     id_pc_d    = pc_q;
                     id_pc4_d   = pc_q + 32'd4;
                     id_instr_d = IMEM_READDATA;
                     id_valid_d = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                     mis_d      = 1'b0;
`endif
                  end
               end else if (!STALL) begin
                  id_pc_d    = 32'h0;
                  id_pc4_d   = 32'h0;
                  id_instr_d = 32'h0;
                  id_valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                  mis_d      = 1'b0;
`endif
               end
            end
            S_HOLD: begin
               if (!STALL) begin
                  id_pc_d    = skid_pc_q;
                  id_pc4_d   = skid_pc_q + 32'd4;
                  id_instr_d = skid_instr_q;
                  id_valid_d = 1'b1;
                  state_d    = S_FETCH;
`ifdef IFU_MISALIGN_TRAP_EN
                  mis_d      = 1'b0;
`endif
               end
            end
            S_DISCARD: begin
               // The returning word belongs to the abandoned path and is never used.
               if (!STALL) begin
                  id_pc_d    = 32'h0;
                  id_pc4_d   = 32'h0;
                  id_instr_d = 32'h0;
                  id_valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                  mis_d      = 1'b0;
`endif
               end
               if (!IMEM_BUSYWAIT) begin
                  state_d = S_FETCH;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         id_pc_q      <= 32'h0;
         id_pc4_q     <= 32'h0;
         id_instr_q   <= 32'h0;
         id_valid_q   <= 1'b0;
         skid_pc_q    <= 32'h0;
         skid_instr_q <= 32'h0;
         disc_addr_q  <= 32'h0;
`ifdef IFU_MISALIGN_TRAP_EN
         mis_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_pc_q      <= id_pc_d;
         id_pc4_q     <= id_pc4_d;
         id_instr_q   <= id_instr_d;
         id_valid_q   <= id_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         disc_addr_q  <= disc_addr_d;
`ifdef IFU_MISALIGN_TRAP_EN
         mis_q        <= mis_d;
`endif
      end
   end

   // Request is suppressed combinationally while reset is held.
   assign IMEM_READ      = read_req & ~RESET;
   assign IMEM_ADDR      = cur_addr;
   assign IF_BUSY        = IMEM_READ & IMEM_BUSYWAIT;
   assign PC_ID          = id_pc_q;
   assign PC4_ID         = id_pc4_q;
   assign INSTRUCTION_ID = id_instr_q;
   assign VALID_ID       = id_valid_q;
   assign dbg_state      = state_q;
`ifdef IFU_MISALIGN_TRAP_EN
   assign MISALIGNED_ID  = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random stall/wait/redirect
// traffic checked against an expected program-order PC stream.
module tb_instruction_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        CLK;
   logic        RESET;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT;
   logic [31:0] PC_ID;
   logic [31:0] PC4_ID;
   logic [31:0] INSTRUCTION_ID;
   logic        VALID_ID;
   logic        IF_BUSY;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   // Expected stream: front is the PC of the next instruction that must reach decode.
   logic [31:0] exp_q[$];
   logic        m_valid;
   logic [31:0] m_pc;
   int          delivered;

   instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
      .BRANCH_TARGET(BRANCH_TARGET), .IMEM_ADDR(IMEM_ADDR), .IMEM_READ(IMEM_READ),
      .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .PC_ID(PC_ID),
      .PC4_ID(PC4_ID), .INSTRUCTION_ID(INSTRUCTION_ID), .VALID_ID(VALID_ID),
      .IF_BUSY(IF_BUSY), .dbg_state(dbg_state)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[17:2], ~a[15:0]};
   endfunction

   assign IMEM_READDATA = IMEM_BUSYWAIT ? 32'hDEAD_BEEF : mem_word(IMEM_ADDR);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(RST_PC);
      m_valid = 1'b0;
      m_pc = 32'h0;
   endtask

   // One clock: drive inputs at the falling edge, check the effect of the rising edge.
   task automatic step(input logic stall, input logic br, input logic [31:0] tgt, input logic busy);
      logic        pend;
      logic [31:0] pend_addr;
      logic [31:0] e;
      STALL = stall;
      BRANCH_TAKEN = br;
      BRANCH_TARGET = tgt;
      IMEM_BUSYWAIT = busy;
      #1;
      pend = IMEM_READ & busy;
      pend_addr = IMEM_ADDR;
      check("if_busy", {31'h0, IF_BUSY}, {31'h0, pend});
      check("addr_align", {30'h0, IMEM_ADDR[1:0]}, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      if (br) begin
         check("flush_valid", {31'h0, VALID_ID}, 32'h0);
         check("flush_instr", INSTRUCTION_ID, 32'h0);
         exp_q.delete();
         exp_q.push_back({tgt[31:2], 2'b00});
         m_valid = 1'b0;
      end else if (stall) begin
         check("hold_valid", {31'h0, VALID_ID}, {31'h0, m_valid});
         if (m_valid) begin
            check("hold_pc", PC_ID, m_pc);
            check("hold_instr", INSTRUCTION_ID, mem_word(m_pc));
         end
      end else if (VALID_ID) begin
         e = exp_q.pop_front();
         exp_q.push_back(e + 32'd4);
         check("stream_pc", PC_ID, e);
         check("stream_pc4", PC4_ID, e + 32'd4);
         check("stream_instr", INSTRUCTION_ID, mem_word(e));
         m_valid = 1'b1;
         m_pc = e;
         delivered++;
      end else begin
         check("bubble_instr", INSTRUCTION_ID, 32'h0);
         m_valid = 1'b0;
      end
      if (pend) begin
         check("pend_read", {31'h0, IMEM_READ}, 32'h1);
         check("pend_addr", IMEM_ADDR, pend_addr);
      end
      BRANCH_TAKEN = 1'b0;
   endtask

   initial begin
      int drain_cnt;
      RESET = 1'b1;
      STALL = 1'b0;
      BRANCH_TAKEN = 1'b0;
      BRANCH_TARGET = 32'h0;
      IMEM_BUSYWAIT = 1'b0;
      delivered = 0;
      model_reset();

      // Reset values and restart address
      @(posedge CLK);
      @(negedge CLK);
      check("rst_valid", {31'h0, VALID_ID}, 32'h0);
      check("rst_instr", INSTRUCTION_ID, 32'h0);
      check("rst_pc_id", PC_ID, 32'h0);
      check("rst_pc4_id", PC4_ID, 32'h0);
      check("rst_read", {31'h0, IMEM_READ}, 32'h0);
      RESET = 1'b0;
      #1;
      check("first_addr", IMEM_ADDR, RST_PC);
      check("first_read", {31'h0, IMEM_READ}, 32'h1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("seq_valid", {31'h0, VALID_ID}, 32'h1);
      check("seq_addr1", IMEM_ADDR, 32'h104);

      // Three wait states on 0x104
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         check("wait_valid", {31'h0, VALID_ID}, 32'h0);
         check("wait_addr", IMEM_ADDR, 32'h104);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("after_wait_pc", PC_ID, 32'h104);

      // Stall while a fetch completes: word parked, request dropped, released in order
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("hold_read1", {31'h0, IMEM_READ}, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("hold_read2", {31'h0, IMEM_READ}, 32'h0);
      check("hold_pc_keep", PC_ID, 32'h104);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("skid_out_pc", PC_ID, 32'h108);
      check("skid_out_valid", {31'h0, VALID_ID}, 32'h1);

      // Redirect while 0x10C is waiting
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("busy_addr_10c", IMEM_ADDR, 32'h10C);
      step(1'b0, 1'b1, 32'h200, 1'b1);
      check("disc_addr1", IMEM_ADDR, 32'h10C);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("disc_addr2", IMEM_ADDR, 32'h10C);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("disc_drop_valid", {31'h0, VALID_ID}, 32'h0);
      check("disc_next_addr", IMEM_ADDR, 32'h200);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("target_pc", PC_ID, 32'h200);

      // Redirect together with stall
      step(1'b1, 1'b1, 32'h300, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("br_stall_pc", PC_ID, 32'h300);

      // Wrap-around and masked low target bits
      step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("wrap_pc_a", PC_ID, 32'hFFFF_FFF8);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("wrap_pc_b", PC_ID, 32'hFFFF_FFFC);
      check("wrap_pc4", PC4_ID, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("wrap_pc_c", PC_ID, 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic        r_stall, r_br, r_busy;
         logic [31:0] r_tgt;
         r_stall = ($urandom_range(0, 99) < 25);
         r_busy  = ($urandom_range(0, 99) < 30);
         r_br    = ($urandom_range(0, 99) < 8);
         r_tgt   = $urandom;
         step(r_stall, r_br, r_tgt, r_busy);
      end
      drain_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         if (VALID_ID) drain_cnt++;
      end
      check("drain_progress", {31'h0, (drain_cnt >= 9)}, 32'h1);

      // Reset in the middle of a wait state
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #2;
      RESET = 1'b1;
      #1;
      check("mid_rst_read", {31'h0, IMEM_READ}, 32'h0);
      check("mid_rst_valid", {31'h0, VALID_ID}, 32'h0);
      check("mid_rst_instr", INSTRUCTION_ID, 32'h0);
      check("mid_rst_pc_id", PC_ID, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      IMEM_BUSYWAIT = 1'b0;
      model_reset();
      #1;
      check("mid_rst_addr", IMEM_ADDR, RST_PC);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check("mid_rst_pc", PC_ID, RST_PC);
      step(1'b0, 1'b0, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage plus IF/ID pipeline register of the RV32IM pipeline.
- Holds the PC and issues word reads to instruction memory over a READ/BUSYWAIT handshake.
- Presents {PC, PC+4, instruction} to the decode stage, whose control unit decodes INSTRUCTION_ID directly.
- Handles hazard-unit stalls, EX-stage redirects (branch/jump) and memory wait states; bubbles are emitted as 32'h00000000 (decoded as nop).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- STALL  in  1  hazard unit: hold IF/ID and PC.
- BRANCH_TAKEN  in  1  EX-stage redirect request.
- BRANCH_TARGET  in  32  redirect address.
- IMEM_ADDR  out  32  instruction memory word address (byte address, [1:0]=00).
- IMEM_READ  out  1  read request.
- IMEM_READDATA  in  32  instruction word, valid on the edge where READ=1 and BUSYWAIT=0.
- IMEM_BUSYWAIT  in  1  memory not ready.
- PC_ID  out  32  PC of the instruction in IF/ID.
- PC4_ID  out  32  PC_ID+4 (for jal/jalr link).
- INSTRUCTION_ID  out  32  instruction to decode; 0 when bubble.
- VALID_ID  out  1  IF/ID holds a real instruction.
- IF_BUSY  out  1  IMEM_READ & IMEM_BUSYWAIT (to hazard unit).

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC; state=FETCH.
  - PC_ID=0, PC4_ID=0, INSTRUCTION_ID=0, VALID_ID=0; IMEM_READ=0 while RESET high.
  - Skid buffer cleared; any in-flight request abandoned.
  - First request issued in the cycle after RESET deasserts.
- States: FETCH, HOLD, DISCARD.
- Outputs by state:
  - IMEM_READ=1 in FETCH and DISCARD, 0 in HOLD.
  - IMEM_ADDR=PC in FETCH/HOLD; in DISCARD = latched address of the dropped request (address stable until BUSYWAIT falls).
- Completion = edge with IMEM_READ=1 and IMEM_BUSYWAIT=0. Best-case throughput 1 instr/cycle (BUSYWAIT never high).
- Priority per edge: RESET > BRANCH_TAKEN > STALL > normal.
- BRANCH_TAKEN=1 (any state):
  - PC<=BRANCH_TARGET; IF/ID<=bubble (flush overrides STALL); skid buffer dropped.
  - Next state DISCARD if a request is outstanding and BUSYWAIT=1, else FETCH.
- FETCH, completion, STALL=0: IF/ID<={PC, PC+4, READDATA}, VALID=1; PC<=PC+4.
- FETCH, completion, STALL=1: IF/ID held; {PC, READDATA} saved in skid buffer; PC<=PC+4; ->HOLD.
- FETCH, BUSYWAIT=1, STALL=0: IF/ID<=bubble; PC held.
- FETCH, BUSYWAIT=1, STALL=1: IF/ID held; PC held.
- HOLD, STALL=1: all held, no request.
- HOLD, STALL=0: IF/ID<=buffer, VALID=1; ->FETCH.
- DISCARD:
  - When BUSYWAIT=0, returned data is dropped and state ->FETCH; IF/ID<=bubble unless STALL.
  - A further redirect while in DISCARD updates PC and stays in DISCARD.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4=0. Same for PC4_ID.
- Without the optional feature, BRANCH_TARGET[1:0] is forced to 00.
- No instruction is ever lost or duplicated across stall/redirect/wait combinations.

Optional Feature:
- Macro IFU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output MISALIGNED_ID (1 bit, reset 0).
  - A redirect with BRANCH_TARGET[1:0]!=0 issues no fetch.
  - IF/ID<={PC_ID=target, INSTRUCTION_ID=0, VALID_ID=0, MISALIGNED_ID=1}.
  - Unit enters TRAP state (IMEM_READ=0, IF/ID held) until the next BRANCH_TAKEN with an aligned target.
- Undefined: no port and no TRAP state; low bits masked.

Test Plan:
- Reset with RESET_PC=0x100, BUSYWAIT=0 -> IMEM_ADDR 0x100,0x104,0x108 on consecutive cycles; VALID_ID=1 from 2nd cycle; PC4_ID=PC_ID+4.
- BUSYWAIT high 3 cycles on 0x104 -> INSTRUCTION_ID=0/VALID_ID=0 for 3 cycles; then 0x104's word appears; no duplicate of 0x100.
- STALL high 2 cycles while a fetch completes -> IF/ID unchanged; IMEM_READ=0 in HOLD; buffered word emitted on first cycle after STALL falls; order preserved.
- BRANCH_TAKEN target 0x200 while 0x10C busy -> IMEM_ADDR stays 0x10C until BUSYWAIT falls, data dropped, then fetch 0x200; IF/ID shows bubble, never 0x10C's word.
- BRANCH_TAKEN and STALL in the same cycle -> IF/ID flushed to bubble; next instruction seen is from target.
- RESET asserted mid-wait (BUSYWAIT=1) -> outputs zero immediately; IMEM_READ=0; after release fetch restarts at RESET_PC.
